pconv_feeder_c1: RTL and testbench



---
 rtl/pconv_feeder_c1_if.sv | 39 +++
 rtl/pconv_feeder_c1.sv | 153 +++++++++++++++
 tb/tb_pconv_feeder_c1.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pconv_feeder_c1_if.sv
// Bus between the partial-conv operand feeder and its environment:
// control, feature-map/weight memory ports and the operand stream.
interface pconv_feeder_c1_if #(
    parameter int N      = 16,
    parameter int ADDR_W = 10,
    parameter int WGT_AW = 4
);
    logic              start;
    logic              hold;
    logic [31:0]       cfg_bias;
    logic [4:0]        cfg_shift;
    logic              img_rd_en;
    logic [ADDR_W-1:0] img_addr;
    logic [N-1:0]      img_rdata;
    logic [WGT_AW-1:0] wgt_addr;
    logic [N-1:0]      wgt_rdata;
    logic              input_vld;
    logic [N-1:0]      input_din;
    logic [N-1:0]      weight_din;
    logic [31:0]       bias_din;
    logic [4:0]        shift_din;
    logic              win_last;
    logic [7:0]        pix_x;
    logic [7:0]        pix_y;
    logic              busy;
    logic              done;

    modport master (
        input  start, hold, cfg_bias, cfg_shift, img_rdata, wgt_rdata,
        output img_rd_en, img_addr, wgt_addr, input_vld, input_din, weight_din,
               bias_din, shift_din, win_last, pix_x, pix_y, busy, done
    );

    modport slave (
        output start, hold, cfg_bias, cfg_shift, img_rdata, wgt_rdata,
        input  img_rd_en, img_addr, wgt_addr, input_vld, input_din, weight_din,
               bias_din, shift_din, win_last, pix_x, pix_y, busy, done
    );
endinterface

// File: rtl/pconv_feeder_c1.sv
// Operand sequencer for the single-channel partial-convolution unit.
// Walks every output pixel and kernel tap, reads image/weight words from
// synchronous memories and streams them with a window-last flag.
module pconv_feeder_c1 #(
    parameter int N           = 16,
    parameter int INPUT_SIZE  = 28,
    parameter int KERNEL_SIZE = 3,
    parameter int STRIDE      = 1,
    parameter int WIN_GAP     = 0,
    parameter int ADDR_W      = 10
) (
    input  logic                clk,
    input  logic                rst,
    pconv_feeder_c1_if.master   bus
);
    localparam int OUT = (INPUT_SIZE - KERNEL_SIZE) / STRIDE + 1;
    localparam int KK  = KERNEL_SIZE * KERNEL_SIZE;
    localparam int WA  = (KK > 1) ? $clog2(KK) : 1;
    localparam int GW  = (WIN_GAP > 0) ? $clog2(WIN_GAP + 1) : 1;

    // Address steps; the address is built incrementally so no multiplier
    // sits on the img_addr path.
    localparam logic [ADDR_W-1:0] A_ROW   = ADDR_W'(INPUT_SIZE);
    localparam logic [ADDR_W-1:0] A_HSTEP = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0] A_VSTEP = ADDR_W'(STRIDE * INPUT_SIZE);
    localparam logic [N-1:0]      ZERO_N  = '0;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_GAP, S_DRAIN, S_DONE} state_t;

    state_t            r_state, w_next;
    logic [7:0]        r_kx, r_ky, r_ox, r_oy;
    logic [ADDR_W-1:0] r_oy_base;   // top-left address of current output row
    logic [ADDR_W-1:0] r_win_base;  // top-left address of current window
    logic [ADDR_W-1:0] r_row_base;  // first address of current kernel row
    logic [ADDR_W-1:0] r_addr;
    logic [WA-1:0]     r_waddr;
    logic [GW-1:0]     r_gap;
    logic [31:0]       r_bias;
    logic [4:0]        r_shift;
    logic              r_vld, r_last;
    logic [7:0]        r_px, r_py;

    logic w_rd, w_accept, w_win_end, w_final, w_gap_end;

    assign w_accept  = (r_state == S_IDLE) && bus.start;
    assign w_rd      = (r_state == S_RUN) && !bus.hold;
    assign w_win_end = (r_kx == 8'(KERNEL_SIZE - 1)) && (r_ky == 8'(KERNEL_SIZE - 1));
    assign w_final   = w_win_end && (r_ox == 8'(OUT - 1)) && (r_oy == 8'(OUT - 1));
    assign w_gap_end = (r_gap == GW'(WIN_GAP - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state: final tap drains, other window ends optionally pause
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_RUN;
            S_RUN: begin
                if (w_rd && w_final)                       w_next = S_DRAIN;
                else if (w_rd && w_win_end && WIN_GAP > 0) w_next = S_GAP;
            end
            S_GAP:   if (w_gap_end) w_next = S_RUN;
            S_DRAIN: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Gap timer runs freely while in GAP, regardless of hold
    always_ff @(posedge clk) begin
        if (rst || r_state != S_GAP) r_gap <= '0;
        else                         r_gap <= r_gap + 1'b1;
    end

    // Tap/pixel counters and incremental address generation
    always_ff @(posedge clk) begin
        if (rst || w_accept || (w_rd && w_final)) begin
            r_kx <= '0; r_ky <= '0; r_ox <= '0; r_oy <= '0;
            r_oy_base <= '0; r_win_base <= '0; r_row_base <= '0;
            r_addr <= '0; r_waddr <= '0;
        end else if (w_rd) begin
            r_waddr <= w_win_end ? '0 : r_waddr + 1'b1;
            if (r_kx != 8'(KERNEL_SIZE - 1)) begin
                r_kx   <= r_kx + 8'd1;
                r_addr <= r_addr + 1'b1;
            end else if (r_ky != 8'(KERNEL_SIZE - 1)) begin
                r_kx       <= '0;
                r_ky       <= r_ky + 8'd1;
                r_row_base <= r_row_base + A_ROW;
                r_addr     <= r_row_base + A_ROW;
            end else if (r_ox != 8'(OUT - 1)) begin
                r_kx       <= '0;
                r_ky       <= '0;
                r_ox       <= r_ox + 8'd1;
                r_win_base <= r_win_base + A_HSTEP;
                r_row_base <= r_win_base + A_HSTEP;
                r_addr     <= r_win_base + A_HSTEP;
            end else begin
                r_kx       <= '0;
                r_ky       <= '0;
                r_ox       <= '0;
                r_oy       <= r_oy + 8'd1;
                r_oy_base  <= r_oy_base + A_VSTEP;
                r_win_base <= r_oy_base + A_VSTEP;
                r_row_base <= r_oy_base + A_VSTEP;
                r_addr     <= r_oy_base + A_VSTEP;
            end
        end
    end

    // Bias/shift captured once per accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bias  <= '0;
            r_shift <= '0;
        end else if (w_accept) begin
            r_bias  <= bus.cfg_bias;
            r_shift <= bus.cfg_shift;
        end
    end

    // Read-response alignment: tags follow the memory's one-cycle latency
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= 1'b0; r_last <= 1'b0; r_px <= '0; r_py <= '0;
        end else begin
            r_vld  <= w_rd;
            r_last <= w_rd && w_win_end;
            if (w_rd) begin
                r_px <= r_ox;
                r_py <= r_oy;
            end
        end
    end

    assign bus.img_rd_en  = w_rd;
    assign bus.img_addr   = r_addr;
    assign bus.wgt_addr   = r_waddr;
    assign bus.input_vld  = r_vld;
    assign bus.input_din  = r_vld ? bus.img_rdata : ZERO_N;
    assign bus.weight_din = r_vld ? bus.wgt_rdata : ZERO_N;
    assign bus.bias_din   = r_bias;
    assign bus.shift_din  = r_shift;
    assign bus.win_last   = r_last;
    assign bus.pix_x      = r_px;
    assign bus.pix_y      = r_py;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = (r_state == S_DONE);
endmodule

// File: tb/tb_pconv_feeder_c1.sv
// Bench for pconv_feeder_c1: three instances (plain, stride 2, window gap)
// checked cycle by cycle against a loop-nest reference and a read schedule.
module tb_pconv_feeder_c1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        st [3];
    logic        hd [3];
    logic [31:0] bias_in [3];
    logic [4:0]  shift_in [3];
    logic        o_rden [3], o_vld [3], o_last [3], o_busy [3], o_done [3];
    logic [9:0]  o_addr [3];
    logic [3:0]  o_waddr [3];
    logic [15:0] o_din [3], o_wd [3];
    logic [31:0] o_bias [3];
    logic [4:0]  o_shift [3];
    logic [7:0]  o_px [3], o_py [3];

    logic [15:0] img_mem [1024];
    logic [15:0] wgt_mem [16];

    for (genvar g = 0; g < 3; g++) begin : gd
        pconv_feeder_c1_if #(.N(16), .ADDR_W(10), .WGT_AW(4)) bus ();
        pconv_feeder_c1 #(
            .N(16), .INPUT_SIZE(g == 1 ? 5 : 4), .KERNEL_SIZE(3),
            .STRIDE(g == 1 ? 2 : 1), .WIN_GAP(g == 2 ? 2 : 0), .ADDR_W(10)
        ) dut (.clk(clk), .rst(rst), .bus(bus));
        assign bus.start     = st[g];
        assign bus.hold      = hd[g];
        assign bus.cfg_bias  = bias_in[g];
        assign bus.cfg_shift = shift_in[g];
        always @(posedge clk) if (bus.img_rd_en) begin
            bus.img_rdata <= img_mem[bus.img_addr];
            bus.wgt_rdata <= wgt_mem[bus.wgt_addr];
        end
        assign o_rden[g]  = bus.img_rd_en;
        assign o_addr[g]  = bus.img_addr;
        assign o_waddr[g] = bus.wgt_addr;
        assign o_vld[g]   = bus.input_vld;
        assign o_din[g]   = bus.input_din;
        assign o_wd[g]    = bus.weight_din;
        assign o_bias[g]  = bus.bias_din;
        assign o_shift[g] = bus.shift_din;
        assign o_last[g]  = bus.win_last;
        assign o_px[g]    = bus.pix_x;
        assign o_py[g]    = bus.pix_y;
        assign o_busy[g]  = bus.busy;
        assign o_done[g]  = bus.done;
    end

    int n_chk = 0;
    int n_pass = 0;

    // reference: expected beats in order and the cycle each should appear
    int          exp_cyc [$];
    logic [15:0] exp_din [$];
    logic [15:0] exp_wd [$];
    bit          exp_last [$];
    int          exp_px [$];
    int          exp_py [$];
    bit          hpat [256];
    int          exp_done;

    function automatic logic any_out(int k);
        return |{o_rden[k], o_addr[k], o_waddr[k], o_vld[k], o_din[k], o_wd[k],
                 o_bias[k], o_shift[k], o_last[k], o_px[k], o_py[k], o_busy[k], o_done[k]};
    endfunction

    task automatic fill_mem(bit rnd);
        for (int a = 0; a < 1024; a++) img_mem[a] = rnd ? 16'($urandom) : 16'(a);
        for (int a = 0; a < 16; a++)   wgt_mem[a] = rnd ? 16'($urandom) : 16'(a + 100);
    endtask

    task automatic build_exp(int k, int hmode);
        int is, s, g, o, c, n;
        is = (k == 1) ? 5 : 4;
        s  = (k == 1) ? 2 : 1;
        g  = (k == 2) ? 2 : 0;
        o  = (is - 3) / s + 1;
        exp_cyc.delete(); exp_din.delete(); exp_wd.delete();
        exp_last.delete(); exp_px.delete(); exp_py.delete();
        for (int c2 = 0; c2 < 256; c2++)
            hpat[c2] = (hmode == 1) ? (c2 >= 5 && c2 <= 7) :
                       (hmode == 2) ? (c2 > 0 && $urandom_range(0, 3) == 0) : 1'b0;
        for (int oy = 0; oy < o; oy++)
            for (int ox = 0; ox < o; ox++)
                for (int ky = 0; ky < 3; ky++)
                    for (int kx = 0; kx < 3; kx++) begin
                        exp_din.push_back(img_mem[(oy * s + ky) * is + ox * s + kx]);
                        exp_wd.push_back(wgt_mem[ky * 3 + kx]);
                        exp_last.push_back(kx == 2 && ky == 2);
                        exp_px.push_back(ox);
                        exp_py.push_back(oy);
                    end
        n = exp_din.size();
        c = 1;
        for (int i = 0; i < n; i++) begin
            while (hpat[c]) c++;
            exp_cyc.push_back(c + 1);
            c++;
            if (exp_last[i] && i != n - 1) c += g;
        end
        exp_done = exp_cyc[n - 1] + 1;
    endtask

    task automatic run_pass(string nm, int k, int hmode, bit mut, int fixed_done,
                            logic [31:0] b, logic [4:0] sh);
        int bi, act_done;
        bit ev;
        build_exp(k, hmode);
        bi = 0;
        act_done = -1;
        bias_in[k] = b;
        shift_in[k] = sh;
        for (int c = 0; c < 250; c++) begin
            hd[k] = hpat[c];
            st[k] = (c == 0) || (mut && (c == 5 || c == 17 || c == exp_done));
            if (mut && c > 0) begin
                bias_in[k]  = $urandom;
                shift_in[k] = 5'($urandom);
            end
            @(negedge clk);
            ev = (bi < exp_cyc.size()) && (exp_cyc[bi] == c);
            n_chk++;
            if (o_vld[k] !== ev)
                $display("FAIL %s vld c=%0d got=%b exp=%b", nm, c, o_vld[k], ev);
            else n_pass++;
            if (ev) begin
                n_chk++;
                if (o_din[k] !== exp_din[bi] || o_wd[k] !== exp_wd[bi] ||
                    o_last[k] !== exp_last[bi] || o_px[k] !== 8'(exp_px[bi]) ||
                    o_py[k] !== 8'(exp_py[bi]))
                    $display("FAIL %s beat%0d got din=%0d w=%0d l=%b x=%0d y=%0d exp din=%0d w=%0d l=%b x=%0d y=%0d",
                             nm, bi, o_din[k], o_wd[k], o_last[k], o_px[k], o_py[k],
                             exp_din[bi], exp_wd[bi], exp_last[bi], exp_px[bi], exp_py[bi]);
                else n_pass++;
                bi++;
            end
            n_chk++;
            if (o_busy[k] !== (c >= 1 && c <= exp_done) || o_done[k] !== (c == exp_done))
                $display("FAIL %s busy/done c=%0d got=%b/%b exp=%b/%b", nm, c,
                         o_busy[k], o_done[k], (c >= 1 && c <= exp_done), (c == exp_done));
            else n_pass++;
            if (o_done[k] === 1'b1 && act_done < 0) act_done = c;
            if (c >= 1) begin
                n_chk++;
                if (o_bias[k] !== b || o_shift[k] !== sh)
                    $display("FAIL %s cfg c=%0d got=%h/%0d exp=%h/%0d", nm, c,
                             o_bias[k], o_shift[k], b, sh);
                else n_pass++;
            end
            @(posedge clk); #1;
            if (c >= exp_done + 3) break;
        end
        st[k] = 1'b0;
        hd[k] = 1'b0;
        n_chk++;
        if (bi != exp_cyc.size())
            $display("FAIL %s beats got=%0d exp=%0d", nm, bi, exp_cyc.size());
        else n_pass++;
        if (fixed_done >= 0) begin
            n_chk++;
            if (act_done != fixed_done)
                $display("FAIL %s done_cycle got=%0d exp=%0d", nm, act_done, fixed_done);
            else n_pass++;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (any_out(k) !== 1'b0) $display("FAIL reset_outs dut%0d got=%b exp=0", k, any_out(k));
            else n_pass++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;  fill_mem(0); run_pass("basic", 0, 0, 0, 38, 32'h1234, 5'd3); endtask
    task automatic test_stride; fill_mem(0); run_pass("stride", 1, 0, 0, 38, 32'h55, 5'd1); endtask
    task automatic test_gap;    fill_mem(0); run_pass("gap", 2, 0, 0, 44, 32'h9, 5'd2); endtask
    task automatic test_hold;   fill_mem(0); run_pass("hold", 0, 1, 0, 41, 32'h7, 5'd4); endtask
    task automatic test_cfg;    fill_mem(0); run_pass("cfg", 0, 0, 1, 38, 32'h40, 5'd7); endtask

    task automatic test_random;
        for (int r = 0; r < 6; r++) begin
            fill_mem(1);
            run_pass("random", r % 3, 2, r[0], -1, $urandom, 5'($urandom));
        end
    endtask

    task automatic test_rst_mid;
        int bad;
        bad = 0;
        fill_mem(0);
        bias_in[0] = 32'hABCD;
        shift_in[0] = 5'd9;
        for (int c = 0; c < 62; c++) begin
            st[0] = (c == 0);
            rst   = (c == 20);
            @(negedge clk);
            if (c == 20) begin
                n_chk++;
                if (o_busy[0] !== 1'b1) $display("FAIL rst_mid busy_before got=%b exp=1", o_busy[0]);
                else n_pass++;
            end
            if (c == 21) begin
                n_chk++;
                if (any_out(0) !== 1'b0) $display("FAIL rst_mid outs got=%b exp=0", any_out(0));
                else n_pass++;
            end
            if (c >= 21 && (o_vld[0] || o_done[0] || o_busy[0])) bad++;
            @(posedge clk); #1;
        end
        n_chk++;
        if (bad != 0) $display("FAIL rst_mid activity_after got=%0d exp=0", bad);
        else n_pass++;
        run_pass("rst_restart", 0, 0, 0, 38, 32'h3, 5'd5);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            st[k] = 1'b0; hd[k] = 1'b0; bias_in[k] = '0; shift_in[k] = '0;
        end
        fill_mem(0);
        @(posedge clk); #1;
        test_reset;
        test_basic;
        test_stride;
        test_gap;
        test_hold;
        test_cfg;
        test_rst_mid;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
